hilo_div: RTL
=============

Name: hilo_div

Overview:
- Multi-cycle 32-bit signed/unsigned divider; the producer side of the HI/LO write port.
- Sits beside the EX stage. EX raises start_i for DIV/DIVU and stalls the pipeline until ready_o.
- Result {remainder, quotient} goes down the pipeline and is written as HI = remainder, LO = quotient.
- Radix-2 restoring algorithm, one quotient bit per clock.

Parameters:
- DATA_W, 32, operand width; result is 2*DATA_W.
- CNT_W, 6, iteration counter width; must hold the value DATA_W.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high (`RstEnable = 1'b1`).
- signed_div_i  input  1  1 = DIV (signed), 0 = DIVU.
- opdata1_i  input  32  dividend.
- opdata2_i  input  32  divisor.
- start_i  input  1  request; held high by EX until ready_o is seen.
- annul_i  input  1  cancel the in-flight divide (exception/flush).
- result_o  output  64  {remainder[63:32], quotient[31:0]}.
- ready_o  output  1  result valid (`DivResultReady`).

Behaviour:
- Reset:
  - state = FREE; result_o = 0; ready_o = 0; counter = 0.
  - Reset wins over every other input, including mid-division.
- States:
  - FREE: idle.
    - If start_i=1 and annul_i=0 and opdata2_i==0: go to BYZERO.
    - Else if start_i=1 and annul_i=0: go to ON.
    - On entering ON: counter = 0, latch |dividend| and |divisor|, latch sign flags, partial remainder = 0.
    - |x| is the two's-complement negation when signed_div_i=1 and x[31]=1; otherwise x unchanged.
  - BYZERO: next edge goes to END with result_o = 0 and ready_o = 1.
  - ON:
    - If annul_i=1: go to FREE, ready_o = 0, result unchanged.
    - Else while counter < 32, each edge does one step:
      - Shift the remainder/dividend pair left by 1.
      - Trial-subtract the divisor from the 33-bit upper part.
      - If there is no borrow, keep the difference and shift in quotient bit 1; otherwise shift in 0.
      - counter += 1.
    - When counter == 32, the next edge applies sign correction, writes result_o, sets ready_o = 1 and goes to END.
  - END:
    - Hold result_o and ready_o = 1 while start_i = 1.
    - When start_i = 0: go to FREE, ready_o = 0, result_o = 0.
- Sign correction (signed only):
  - Quotient is negated if the operand signs differ.
  - Remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0 (wraps, no trap).
- Latency:
  - Let E0 be the edge that samples start_i in FREE.
  - Steps occur on E1..E32; ready_o is high after E33.
  - Divide-by-zero: ready_o is high after E1.
- Operand sampling:
  - Operands and signed_div_i are sampled only at E0.
  - Changes to them during ON or END are ignored.
- annul_i:
  - Ignored in BYZERO and END.
  - In FREE it blocks a start.
- A new division cannot begin until start_i has been low for at least one edge in END.
- result_o is registered; there is no combinational input-to-output path.

Decomposition:
- defines.v gains:
  - DivFree 2'b00, DivByZero 2'b01, DivOn 2'b10, DivEnd 2'b11
  - DivResultReady 1'b1, DivResultNotReady 1'b0
  - DivStart 1'b1, DivStop 1'b0
  - DoubleRegBus [63:0]
- No sub-module: the trial subtract is a single 33-bit subtraction inline. The FSM plus datapath fits in one module.

Test Plan:
- Unsigned 7 / 2, start held: ready_o rises after E33; result_o = {0x00000001, 0x00000003}; ready_o stays high until start drops, then goes to 0 the next edge.
- Signed -7 / 2 (0xFFFFFFF9 / 0x00000002): result_o = {0xFFFFFFFF, 0xFFFFFFFD}. Also 7 / -2 gives {0x00000001, 0xFFFFFFFD}.
- Divide-by-zero, 0x12345678 / 0: ready_o high after E1; result_o = 0.
- Unsigned 0xFFFFFFFF / 1 gives {0, 0xFFFFFFFF}. Signed 0x80000000 / 0xFFFFFFFF gives {0, 0x80000000}.
- annul_i pulsed at E10 of a 100 / 3 divide: state FREE, ready_o never asserts. A following 100 / 3 start then completes with {1, 33} at E33.
- rst asserted at E15 mid-divide: next cycle ready_o = 0, result_o = 0, state FREE. Operands changed during ON do not affect the result of an uninterrupted run.

Source files
------------

// File: rtl/hilo_div_pkg.sv
// Shared types and constants for the HI/LO radix-2 restoring divider.
// The FSM encoding matches the pipeline's DivFree/DivByZero/DivOn/DivEnd codes.
package hilo_div_pkg;

  localparam int DIV_DATA_W = 32;
  localparam int DIV_CNT_W  = 6;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
  localparam logic RST_ENABLE           = 1'b1;

endpackage

// File: rtl/hilo_div.sv
// Multi-cycle signed/unsigned divider producing {remainder, quotient} for HI/LO.
// Radix-2 restoring: one quotient bit per clock, sign fix-up on the final edge.
module hilo_div
  import hilo_div_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W,
  parameter int CNT_W  = DIV_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [DATA_W-1:0] abs_of(input logic [DATA_W-1:0] x,
                                               input logic               is_signed);
    if (is_signed && x[DATA_W-1]) begin
      abs_of = -x;
    end else begin
      abs_of = x;
    end
  endfunction

  div_state_e        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_rem;
  logic [DATA_W-1:0] r_quo;
  logic [DATA_W-1:0] r_divisor;
  logic              r_neg_q;
  logic              r_neg_r;

  logic [DATA_W:0]   w_upper;
  logic [DATA_W:0]   w_diff;
  logic              w_borrow;
  logic [DATA_W-1:0] w_rem_next;
  logic [DATA_W-1:0] w_quo_next;
  logic [DATA_W-1:0] w_quo_fix;
  logic [DATA_W-1:0] w_rem_fix;

  // Trial subtraction for one restoring step plus final sign correction.
  always_comb begin
    w_upper    = {r_rem, r_quo[DATA_W-1]};
    // The partial remainder is always below 2*divisor, so bit DATA_W of the
    // 33-bit difference is set exactly when the subtraction borrows.
    w_diff     = w_upper - {1'b0, r_divisor};
    w_borrow   = w_diff[DATA_W];
    w_rem_next = w_upper[DATA_W-1:0];
    w_quo_next = {r_quo[DATA_W-2:0], 1'b0};
    w_quo_fix  = r_quo;
    w_rem_fix  = r_rem;
    if (w_borrow) begin
      w_rem_next = w_upper[DATA_W-1:0];
      w_quo_next = {r_quo[DATA_W-2:0], 1'b0};
    end else begin
      w_rem_next = w_diff[DATA_W-1:0];
      w_quo_next = {r_quo[DATA_W-2:0], 1'b1};
    end
    if (r_neg_q) begin
      w_quo_fix = -r_quo;
    end else begin
      w_quo_fix = r_quo;
    end
    if (r_neg_r) begin
      w_rem_fix = -r_rem;
    end else begin
      w_rem_fix = r_rem;
    end
  end

  // Divider FSM, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      r_state   <= DIV_FREE;
      r_cnt     <= {CNT_W{1'b0}};
      r_rem     <= {DATA_W{1'b0}};
      r_quo     <= {DATA_W{1'b0}};
      r_divisor <= {DATA_W{1'b0}};
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      result_o  <= {(2*DATA_W){1'b0}};
      ready_o   <= DIV_RESULT_NOT_READY;
    end else begin
      case (r_state)
        DIV_FREE: begin
          ready_o <= DIV_RESULT_NOT_READY;
          if (start_i == DIV_START && annul_i == 1'b0) begin
            if (opdata2_i == {DATA_W{1'b0}}) begin
              r_state <= DIV_BYZERO;
            end else begin
              r_state   <= DIV_ON;
              r_cnt     <= {CNT_W{1'b0}};
              r_rem     <= {DATA_W{1'b0}};
              r_quo     <= abs_of(opdata1_i, signed_div_i);
              r_divisor <= abs_of(opdata2_i, signed_div_i);
              r_neg_q   <= signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
              r_neg_r   <= signed_div_i & opdata1_i[DATA_W-1];
            end
          end else begin
            r_state <= DIV_FREE;
          end
        end
        DIV_BYZERO: begin
          r_state  <= DIV_END;
          result_o <= {(2*DATA_W){1'b0}};
          ready_o  <= DIV_RESULT_READY;
        end
        DIV_ON: begin
          if (annul_i == 1'b1) begin
            r_state <= DIV_FREE;
            ready_o <= DIV_RESULT_NOT_READY;
          end else if (r_cnt != LAST_CNT) begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
            r_cnt <= r_cnt + CNT_ONE;
          end else begin
            result_o <= {w_rem_fix, w_quo_fix};
            ready_o  <= DIV_RESULT_READY;
            r_state  <= DIV_END;
          end
        end
        DIV_END: begin
          if (start_i == DIV_STOP) begin
            r_state  <= DIV_FREE;
            ready_o  <= DIV_RESULT_NOT_READY;
            result_o <= {(2*DATA_W){1'b0}};
          end else begin
            ready_o <= DIV_RESULT_READY;
          end
        end
        default: begin
          r_state  <= DIV_FREE;
          ready_o  <= DIV_RESULT_NOT_READY;
          result_o <= {(2*DATA_W){1'b0}};
        end
      endcase
    end
  end

endmodule
